// File: rtl/window_mac.sv
// window_mac
//   Pipelined K_BYTES-tap multiply-accumulate stage that sits behind the byte
//   window register. It follows the same byte-shift qualifier as the window,
//   decides when the window holds a complete kernel footprint (fill, then every
//   STRIDE-th shift), and produces the signed dot product of the unsigned
//   window bytes against K_BYTES signed weights loaded serially.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset (clears weights too)
//   i_shift    a byte entered the window this cycle
//   i_window   window contents, byte 0 (LSBs) newest
//   i_w_load   shift i_w_byte into the weight register (byte 0)
//   i_w_byte   signed weight byte
//   i_clear    synchronous restart of counters/pipeline/overrun, weights kept
//   i_ready    downstream accepts o_result
//   o_result   signed dot product, ACC_WIDTH bits
//   o_valid    o_result valid, held until accepted
//   o_w_ready  all K_BYTES weights loaded
//   o_overrun  sticky: a launch was dropped because the pipeline was stalled
//
// Timing: launching shift in cycle t -> launch_q in t+1 (window and weights
// sampled) -> products t+2 -> partial sums t+3 -> o_valid in t+4.
module window_mac #(
  parameter int BYTE_WIDTH = 8,
  parameter int K_BYTES    = 9,
  parameter int WIND_WIDTH = BYTE_WIDTH * K_BYTES,
  parameter int STRIDE     = 1,
  parameter int ACC_WIDTH  = 2 * BYTE_WIDTH + 1 + $clog2(K_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift,
  input  logic [WIND_WIDTH-1:0] i_window,
  input  logic                  i_w_load,
  input  logic [BYTE_WIDTH-1:0] i_w_byte,
  input  logic                  i_clear,
  input  logic                  i_ready,
  output logic [ACC_WIDTH-1:0]  o_result,
  output logic                  o_valid,
  output logic                  o_w_ready,
  output logic                  o_overrun
);

  localparam int PROD_W = 2 * BYTE_WIDTH + 1;
  localparam int CNT_W  = $clog2(K_BYTES + 1);
  localparam int GRP    = (K_BYTES + 2) / 3;

  localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(K_BYTES);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_BYTES - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STRIDE - 1);

  // Counters / launch
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] stride_q, stride_d;
  logic             launch_q, launch_d;

  // Weights
  logic [WIND_WIDTH-1:0] w_q, w_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic                  w_ready;

  // Pipeline
  logic signed [PROD_W-1:0]    prod_q [K_BYTES];
  logic signed [PROD_W-1:0]    prod_d [K_BYTES];
  logic                        p1_valid_q, p1_valid_d;
  logic signed [ACC_WIDTH-1:0] part_q [3];
  logic signed [ACC_WIDTH-1:0] part_d [3];
  logic                        p2_valid_q, p2_valid_d;
  logic signed [ACC_WIDTH-1:0] res_q, res_d;
  logic                        valid_q, valid_d;
  logic                        overrun_q, overrun_d;

  logic stall;
  logic sample;

  assign w_ready   = (wcnt_q == K_CNT);
  assign stall     = valid_q & ~i_ready;
  assign sample    = launch_q & w_ready;

  assign o_result  = res_q;
  assign o_valid   = valid_q;
  assign o_w_ready = w_ready;
  assign o_overrun = overrun_q;

  // Fill counter saturates at K_BYTES; the shift reaching it is the first
  // launch, after which the stride counter launches every STRIDE-th shift.
  always_comb begin
    fill_d   = fill_q;
    stride_d = stride_q;
    launch_d = 1'b0;
    if (i_clear) begin
      fill_d   = '0;
      stride_d = '0;
    end else if (i_shift) begin
      if (fill_q != K_CNT) begin
        fill_d   = fill_q + 1'b1;
        launch_d = (fill_q == K_LAST);
      end else if (stride_q == S_LAST) begin
        stride_d = '0;
        launch_d = 1'b1;
      end else begin
        stride_d = stride_q + 1'b1;
      end
    end
  end

  // Last weight loaded lands in byte 0, pairing with the newest pixel.
  always_comb begin
    w_d    = w_q;
    wcnt_d = wcnt_q;
    if (i_w_load) begin
      w_d = {w_q[WIND_WIDTH-BYTE_WIDTH-1:0], i_w_byte};
      if (wcnt_q != K_CNT) begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // Whole pipeline freezes on stall; a launch arriving then is lost and
  // flagged (only when weights are complete, otherwise dropped silently).
  always_comb begin
    p1_valid_d = p1_valid_q;
    prod_d     = prod_q;
    p2_valid_d = p2_valid_q;
    part_d     = part_q;
    valid_d    = valid_q;
    res_d      = res_q;
    overrun_d  = overrun_q;
    if (i_clear) begin
      p1_valid_d = 1'b0;
      p2_valid_d = 1'b0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
    end else if (stall) begin
      if (sample) begin
        overrun_d = 1'b1;
      end
    end else begin
      p1_valid_d = sample;
      if (sample) begin
        for (int unsigned k = 0; k < K_BYTES; k++) begin
          prod_d[k] =
            $signed({{(PROD_W-BYTE_WIDTH){1'b0}}, i_window[k*BYTE_WIDTH +: BYTE_WIDTH]}) *
            $signed({{(PROD_W-BYTE_WIDTH){w_q[k*BYTE_WIDTH+BYTE_WIDTH-1]}},
                     w_q[k*BYTE_WIDTH +: BYTE_WIDTH]});
        end
      end
      p2_valid_d = p1_valid_q;
      for (int unsigned g = 0; g < 3; g++) begin
        part_d[g] = '0;
        for (int unsigned j = 0; j < GRP; j++) begin
          if (g * GRP + j < K_BYTES) begin
            part_d[g] = part_d[g] +
              {{(ACC_WIDTH-PROD_W){prod_q[g*GRP+j][PROD_W-1]}}, prod_q[g*GRP+j]};
          end
        end
      end
      valid_d = p2_valid_q;
      if (p2_valid_q) begin
        res_d = part_q[0] + part_q[1] + part_q[2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= '0;
      stride_q   <= '0;
      launch_q   <= 1'b0;
      w_q        <= '0;
      wcnt_q     <= '0;
      prod_q     <= '{default: '0};
      p1_valid_q <= 1'b0;
      part_q     <= '{default: '0};
      p2_valid_q <= 1'b0;
      res_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      stride_q   <= stride_d;
      launch_q   <= launch_d;
      w_q        <= w_d;
      wcnt_q     <= wcnt_d;
      prod_q     <= prod_d;
      p1_valid_q <= p1_valid_d;
      part_q     <= part_d;
      p2_valid_q <= p2_valid_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_window_mac.sv
// Bench for window_mac: two instances (STRIDE=1 and STRIDE=3) share one
// stimulus stream. A transaction-level model (shift count since clear,
// weight array, plain dot product, three-slot delay line that holds on
// stall) is compared with both DUTs on every falling edge; directed
// sections pin the model with hand-computed literals.
module tb_window_mac;

  localparam int BW = 8;
  localparam int K  = 9;
  localparam int WW = BW * K;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_shift, i_w_load, i_clear, i_ready;
  logic [BW-1:0] i_w_byte;
  logic [WW-1:0] win;

  logic [AW-1:0] res0, res1;
  logic          v0, v1, wr0, wr1, ov0, ov1;

  int checks = 0;
  int fails  = 0;
  int acc_cnt [2];

  // model state
  int m_w [K];
  int m_wcnt = 0;
  int m_nshift [2];
  bit m_lp [2];
  bit m_p1v [2];
  bit m_p2v [2];
  bit m_ov [2];
  bit m_overrun [2];
  int m_p1 [2];
  int m_p2 [2];
  int m_res [2];
  int strd [2] = '{1, 3};

  always #5 clk = ~clk;

  window_mac #(.BYTE_WIDTH(BW), .K_BYTES(K), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst), .i_shift(i_shift), .i_window(win),
    .i_w_load(i_w_load), .i_w_byte(i_w_byte), .i_clear(i_clear),
    .i_ready(i_ready), .o_result(res0), .o_valid(v0),
    .o_w_ready(wr0), .o_overrun(ov0)
  );

  window_mac #(.BYTE_WIDTH(BW), .K_BYTES(K), .STRIDE(3)) u_s3 (
    .clk(clk), .rst(rst), .i_shift(i_shift), .i_window(win),
    .i_w_load(i_w_load), .i_w_byte(i_w_byte), .i_clear(i_clear),
    .i_ready(i_ready), .o_result(res1), .o_valid(v1),
    .o_w_ready(wr1), .o_overrun(ov1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < K; k++) s += int'(win[k*BW +: BW]) * m_w[k];
    return s;
  endfunction

  // Behavioural model, advanced on the same edges as the DUT.
  initial begin
    bit stall, sv;
    int sval;
    for (int i = 0; i < 2; i++) begin
      m_nshift[i] = 0; m_lp[i] = 0; m_p1v[i] = 0; m_p2v[i] = 0; m_ov[i] = 0;
      m_overrun[i] = 0; m_p1[i] = 0; m_p2[i] = 0; m_res[i] = 0; acc_cnt[i] = 0;
    end
    for (int k = 0; k < K; k++) m_w[k] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_nshift[i] = 0; m_lp[i] = 0; m_p1v[i] = 0; m_p2v[i] = 0; m_ov[i] = 0;
          m_overrun[i] = 0; m_res[i] = 0;
        end
        for (int k = 0; k < K; k++) m_w[k] = 0;
        m_wcnt = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          stall = m_ov[i] && !i_ready;
          if (i_clear) begin
            m_lp[i] = 0; m_p1v[i] = 0; m_p2v[i] = 0; m_ov[i] = 0;
            m_overrun[i] = 0; m_nshift[i] = 0;
          end else begin
            sv = 0;
            sval = 0;
            if (m_lp[i] && m_wcnt == K) begin
              if (stall) m_overrun[i] = 1;
              else begin sv = 1; sval = dot(); end
            end
            if (!stall) begin
              if (m_p2v[i]) m_res[i] = m_p2[i];
              m_ov[i]  = m_p2v[i];
              m_p2v[i] = m_p1v[i]; m_p2[i] = m_p1[i];
              m_p1v[i] = sv;       m_p1[i] = sval;
            end
            m_lp[i] = 0;
            if (i_shift) begin
              m_nshift[i]++;
              m_lp[i] = (m_nshift[i] == K) ||
                        (m_nshift[i] > K && (m_nshift[i] - K) % strd[i] == 0);
            end
          end
        end
        if (i_w_load) begin
          for (int k = K - 1; k > 0; k--) m_w[k] = m_w[k-1];
          m_w[0] = int'($signed(i_w_byte));
          if (m_wcnt < K) m_wcnt++;
        end
      end
    end
  end

  task automatic chk_inst(input int i, input logic v, input logic [AW-1:0] r,
                          input logic wr, input logic ov);
    chk($sformatf("valid[%0d]", i), int'(v), int'(m_ov[i]));
    if (m_ov[i]) chk($sformatf("result[%0d]", i), int'($signed(r)), m_res[i]);
    chk($sformatf("w_ready[%0d]", i), int'(wr), int'(m_wcnt == K));
    chk($sformatf("overrun[%0d]", i), int'(ov), int'(m_overrun[i]));
    if (v && i_ready) acc_cnt[i]++;
  endtask

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      chk_inst(0, v0, res0, wr0, ov0);
      chk_inst(1, v1, res1, wr1, ov1);
    end
  end

  task automatic step(input bit sh, input logic [BW-1:0] p, input bit wl,
                      input logic [BW-1:0] wb, input bit clr, input bit rdy);
    i_shift = sh; i_w_load = wl; i_w_byte = wb; i_clear = clr; i_ready = rdy;
    @(posedge clk);
    #1;
    if (sh) win = {win[WW-BW-1:0], p};
    i_shift = 1'b0; i_w_load = 1'b0; i_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 0, 8'h00, 0, 1);
  endtask

  task automatic shift_rand(input int n, input bit rdy);
    repeat (n) step(1, 8'($urandom), 0, 8'h00, 0, rdy);
  endtask

  task automatic load_rand_w();
    repeat (K) step(0, 8'h00, 1, 8'($urandom), 0, 1);
  endtask

  // Clear, load K copies of wb, shift K pixels, check exact latency and value.
  task automatic kernel(input logic [BW-1:0] wb, input bit incr,
                        input logic [BW-1:0] p, input int exp, input string tag);
    step(0, 8'h00, 0, 8'h00, 1, 1);
    repeat (K) step(0, 8'h00, 1, wb, 0, 1);
    chk({tag, "_wready"}, int'(wr0), 1);
    for (int n = 1; n <= K; n++) begin
      step(1, incr ? 8'(n) : p, 0, 8'h00, 0, 1);
      chk({tag, "_early"}, int'(v0), 0);
    end
    idle(1); chk({tag, "_early"}, int'(v0), 0);
    idle(1); chk({tag, "_early"}, int'(v0), 0);
    idle(1);
    chk({tag, "_valid_t4"}, int'(v0), 1);
    chk({tag, "_res_s1"}, int'($signed(res0)), exp);
    chk({tag, "_res_s3"}, int'($signed(res1)), exp);
    chk({tag, "_model"}, m_res[0], exp);
    idle(1);
    chk({tag, "_single"}, int'(v0), 0);
    idle(3);
  endtask

  initial begin
    int b0, b1;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int b0, b1;
    win = '0; rst = 1'b1; i_shift = 1'b0; i_w_load = 1'b0; i_w_byte = '0;
    i_clear = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", int'(res0), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_wready", int'(wr0), 0);
    chk("rst_overrun", int'(ov0), 0);
    rst = 1'b0;
    idle(2);

    kernel(8'h01, 1, 8'h00, 45, "ones");
    kernel(8'hFF, 0, 8'hFF, -2295, "neg1");
    kernel(8'h80, 0, 8'hFF, -293760, "min");

    // stride: 15 consecutive shifts
    step(0, 8'h00, 0, 8'h00, 1, 1);
    b0 = acc_cnt[0]; b1 = acc_cnt[1];
    shift_rand(15, 1);
    idle(8);
    chk("stride1_results", acc_cnt[0] - b0, 7);
    chk("stride3_results", acc_cnt[1] - b1, 3);

    // stall with continuous shifts
    load_rand_w();
    step(0, 8'h00, 0, 8'h00, 1, 1);
    shift_rand(12, 1);
    chk("prestall_valid", int'(v0), 1);
    chk("prestall_overrun", int'(ov0), 0);
    shift_rand(6, 0);
    chk("stall_overrun", int'(ov0), 1);
    chk("stall_valid_held", int'(v0), 1);
    shift_rand(4, 1);
    idle(8);

    // asynchronous reset with results in flight
    step(0, 8'h00, 0, 8'h00, 1, 1);
    shift_rand(11, 1);
    #2; rst = 1'b1; #1;
    chk("arst_result", int'(res0), 0);
    chk("arst_valid", int'(v0), 0);
    chk("arst_wready", int'(wr0), 0);
    chk("arst_overrun", int'(ov0), 0);
    chk("arst_wready_s3", int'(wr1), 0);
    @(posedge clk); #1; rst = 1'b0;
    b0 = acc_cnt[0]; b1 = acc_cnt[1];
    shift_rand(12, 1);
    idle(6);
    chk("noweights_s1", acc_cnt[0] - b0, 0);
    chk("noweights_s3", acc_cnt[1] - b1, 0);
    chk("noweights_overrun", int'(ov0), 0);
    load_rand_w();
    chk("reload_wready", int'(wr0), 1);
    b0 = acc_cnt[0]; b1 = acc_cnt[1];
    shift_rand(1, 1);
    idle(6);
    chk("reload_s1", acc_cnt[0] - b0, 1);
    chk("reload_s3", acc_cnt[1] - b1, 0);

    // clear mid-fill
    step(0, 8'h00, 0, 8'h00, 1, 1);
    shift_rand(5, 1);
    step(0, 8'h00, 0, 8'h00, 1, 1);
    b0 = acc_cnt[0]; b1 = acc_cnt[1];
    shift_rand(8, 1);
    idle(6);
    chk("midfill_8_s1", acc_cnt[0] - b0, 0);
    chk("midfill_8_s3", acc_cnt[1] - b1, 0);
    chk("midfill_wready", int'(wr0), 1);
    shift_rand(1, 1);
    idle(6);
    chk("midfill_9_s1", acc_cnt[0] - b0, 1);
    chk("midfill_9_s3", acc_cnt[1] - b1, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           8'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
